pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the five-stage pipeline. It drives forwarding selects into EX, load-use stalls and branch flushes on the F/D/E pipeline registers, and a variable-latency data-memory handshake that freezes the whole pipeline while an M-stage load or store waits. It also counts stall cycles and flags memory timeouts.

## Interface
- TIMEOUT, 255: maximum stall cycles for one memory access before a forced release.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- rs1_d, rs2_d  in  5 each  source registers in D.
- rs1_e, rs2_e, rd_e  in  5 each  source and destination registers in E.
- result_src_e  in  2  value 2'b01 marks a load in E.
- pc_src_e  in  1  taken branch or jump resolved in E.
- rd_m  in  5  destination register in M.
- reg_write_m  in  1  register write enable in M.
- result_src_m  in  2  result select in M.
- mem_write_m  in  1  store in M.
- rd_w  in  5  destination register in W.
- reg_write_w  in  1  register write enable in W.
- dmem_ready  in  1  data memory completes the access this cycle.
- forward_a_e, forward_b_e  out  2 each  forwarding selects: 00 register file, 01 W result, 10 M ALU result.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- flush_d, flush_e  out  1 each  bubble into IF/ID and ID/EX.
- flush_w  out  1  bubble into MEM/WB.
- dmem_req  out  1  data memory request.
- dmem_timeout  out  1  sticky timeout error.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- mem_access_m = mem_write_m | (result_src_m == 2'b01).
- Forwarding, rs1_e (rs2_e is identical):
  - 10 if reg_write_m and rd_m != 0 and rd_m == rs1_e.
  - Otherwise 01 if reg_write_w and rd_w != 0 and rd_w == rs1_e.
  - Otherwise 00.
  - M takes priority over W.
- lw_stall = (result_src_e == 2'b01) and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d).
- Memory FSM, states IDLE and WAIT, with an internal wait_cnt:
  - IDLE with mem_access_m and !dmem_ready: go to WAIT, wait_cnt <= 1.
  - IDLE with dmem_ready: zero-wait access, stay in IDLE.
  - WAIT with dmem_ready: go to IDLE.
  - WAIT with !dmem_ready and wait_cnt < TIMEOUT: wait_cnt increments.
  - WAIT with wait_cnt == TIMEOUT and !dmem_ready: forced release, go to IDLE, set dmem_timeout at that edge.
- dmem_req = mem_access_m in both states.
- mem_stall = mem_access_m & !dmem_ready, except forced to 0 on the forced-release cycle.
- Outputs while mem_stall = 1:
  - stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1.
  - flush_d = flush_e = 0. Stall dominates the branch flush and lw_stall; the held EX branch flushes on the release cycle.
- Outputs while mem_stall = 0:
  - stall_f = stall_d = lw_stall.
  - stall_e = stall_m = flush_w = 0.
  - flush_d = pc_src_e.
  - flush_e = lw_stall | pc_src_e.
- Stall counting:
  - stall_count increments on every cycle with mem_stall or lw_stall.
  - It saturates at all-ones.
- dmem_timeout stays high until reset.

## Timing
- All stall, flush, forward and dmem_req outputs are combinational from the current inputs and state, valid within the same cycle.
- State, wait_cnt, dmem_timeout and stall_count update on the posedge of clk.
- A zero-wait access (dmem_ready in the same cycle as dmem_req) causes no stall cycles.
- An access whose dmem_ready arrives N cycles after dmem_req first rises stalls exactly N cycles.
  - The pipeline advances at the edge that ends the ready cycle.
- Timeout: an access that never sees dmem_ready stalls exactly TIMEOUT cycles, and the next cycle releases.
- Back-to-back accesses: the next instruction arriving in M is evaluated from IDLE with no idle gap.
- Reset low, asynchronously and at any time including mid-WAIT:
  - state becomes IDLE, wait_cnt = 0, stall_count = 0, dmem_timeout = 0.
  - All outputs are forced to 0 while reset is low.
  - On release, normal operation resumes at the first edge.

## Test plan
- Forwarding priority: reg_write_m=1, rd_m=5; reg_write_w=1, rd_w=5; rs1_e=5, rs2_e=0 -> forward_a_e=10, forward_b_e=00. Repeat with rd_m=0 -> forward_a_e=01.
- Load-use: result_src_e=01, rd_e=7, rs2_d=7, no memory access -> stall_f=stall_d=flush_e=1, flush_d=0 for one cycle; stall_count=1. Repeat with rd_e=0 -> no stall.
- Branch flush: pc_src_e=1 with lw_stall=0 -> flush_d=flush_e=1, no stall.
- Memory wait: mem_write_m=1, dmem_ready low for 3 cycles then high -> all stalls and flush_w high for 3 cycles, dmem_req high for 4 cycles, stall_count=3, FSM back in IDLE. Repeat with pc_src_e=1 held during the wait -> flush_d/flush_e=0 during stall, 1 on the ready cycle.
- Timeout (TIMEOUT=4): load in M, dmem_ready held low -> stall for 4 cycles, released on the 5th, dmem_timeout=1 from the following edge and sticky.
- Reset mid-WAIT: drop reset in the 2nd stall cycle -> all outputs 0 immediately, stall_count=0, dmem_timeout=0; after release, a new zero-wait access produces no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory handshake between the hazard controller and the data memory.
//
// Handshake: dmem_req is high for every cycle an M-stage load or store is
// present. The access completes in the cycle where dmem_req and dmem_ready
// are both high. dmem_ready may already be high in the first request cycle,
// which is a zero-wait access. The request is never withdrawn while the
// memory is still pending, because the controller freezes the pipeline.
//
// Signals:
//   dmem_req    controller -> memory  access pending in M
//   dmem_ready  memory -> controller  access completes this cycle
interface pipe_hazard_ctrl_if;
    logic dmem_req;
    logic dmem_ready;

    modport master (output dmem_req, input dmem_ready);
    modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
//
// Responsibilities:
//   - EX-stage forwarding selects.
//   - Load-use stall.
//   - Branch flush.
//   - Freezing the whole pipeline while an M-stage memory access waits on
//     dmem_ready, with a forced release after TIMEOUT stall cycles.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   rs1_d, rs2_d           D-stage source registers
//   rs1_e, rs2_e, rd_e     E-stage sources and destination
//   result_src_e           2'b01 marks a load in E
//   pc_src_e               taken branch/jump resolved in E
//   rd_m, reg_write_m      M-stage destination and write enable
//   result_src_m           M-stage result select (2'b01 = load)
//   mem_write_m            store in M
//   rd_w, reg_write_w      W-stage destination and write enable
//   dmem                   data-memory handshake (master side)
//   forward_a_e/_b_e       00 regfile, 01 W result, 10 M ALU result
//   stall_f/d/e/m          hold PC, IF/ID, ID/EX, EX/MEM
//   flush_d/e/w            bubble into IF/ID, ID/EX, MEM/WB
//   dmem_timeout           sticky forced-release flag
//   stall_count            saturating count of stall cycles
//   mem_state_dbg          memory FSM state (0 = IDLE, 1 = WAIT)
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          rs1_d,
    input  logic [4:0]          rs2_d,
    input  logic [4:0]          rs1_e,
    input  logic [4:0]          rs2_e,
    input  logic [4:0]          rd_e,
    input  logic [1:0]          result_src_e,
    input  logic                pc_src_e,
    input  logic [4:0]          rd_m,
    input  logic                reg_write_m,
    input  logic [1:0]          result_src_m,
    input  logic                mem_write_m,
    input  logic [4:0]          rd_w,
    input  logic                reg_write_w,
    pipe_hazard_ctrl_if.master  dmem,
    output logic [1:0]          forward_a_e,
    output logic [1:0]          forward_b_e,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                stall_m,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_w,
    output logic                dmem_timeout,
    output logic [CNT_W-1:0]    stall_count,
    output logic                mem_state_dbg
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    mem_state_e         state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic mem_access_m;
    logic lw_stall;
    logic force_rel;
    logic mem_stall;

    // M has priority over W because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign mem_access_m = mem_write_m | (result_src_m == 2'b01);
    assign lw_stall     = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                          ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Memory FSM next state. In WAIT the counter holds the number of stall
    // cycles already spent; once it reaches TIMEOUT without ready, the
    // current cycle is released instead of stalled.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        force_rel  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_access_m && !dmem.dmem_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                // A vanished access cannot normally happen while frozen;
                // fall back to IDLE rather than stall on nothing.
                if (dmem.dmem_ready || !mem_access_m) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(TIMEOUT)) begin
                    force_rel  = 1'b1;
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign mem_stall = mem_access_m && !dmem.dmem_ready && !force_rel;

    always_comb begin
        stall_count_d = stall_count_q;
        if ((mem_stall || lw_stall) && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Pipeline controls. A memory stall freezes every stage and suppresses
    // the branch flush and load-use bubble; the branch held in EX flushes on
    // the release cycle instead. All outputs are held at 0 during reset.
    always_comb begin
        forward_a_e   = 2'b00;
        forward_b_e   = 2'b00;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_w       = 1'b0;
        dmem.dmem_req = 1'b0;
        if (reset) begin
            forward_a_e   = fwd_sel(rs1_e);
            forward_b_e   = fwd_sel(rs2_e);
            dmem.dmem_req = mem_access_m;
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = lw_stall;
                stall_d = lw_stall;
                flush_d = pc_src_e;
                flush_e = lw_stall | pc_src_e;
            end
        end
    end

    assign dmem_timeout  = timeout_q;
    assign stall_count   = stall_count_q;
    assign mem_state_dbg = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]       result_src_e, result_src_m;
    logic             pc_src_e, reg_write_m, mem_write_m, reg_write_w;
    logic [1:0]       forward_a_e, forward_b_e;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic             mem_state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    pipe_hazard_ctrl_if dmem_if ();

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .result_src_e (result_src_e),
        .pc_src_e     (pc_src_e),
        .rd_m         (rd_m),
        .reg_write_m  (reg_write_m),
        .result_src_m (result_src_m),
        .mem_write_m  (mem_write_m),
        .rd_w         (rd_w),
        .reg_write_w  (reg_write_w),
        .dmem         (dmem_if.master),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .dmem_timeout (dmem_timeout),
        .stall_count  (stall_count),
        .mem_state_dbg(mem_state_dbg)
    );

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, dmem_req}
    wire [7:0] ctl = {stall_f, stall_d, stall_e, stall_m,
                      flush_d, flush_e, flush_w, dmem_if.dmem_req};

    localparam logic [7:0] CTL_IDLE   = 8'b0000_0000;
    localparam logic [7:0] CTL_MSTALL = 8'b1111_0011;
    localparam logic [7:0] CTL_REQ    = 8'b0000_0001;
    localparam logic [7:0] CTL_LWS    = 8'b1100_0100;
    localparam logic [7:0] CTL_BR     = 8'b0000_1100;
    localparam logic [7:0] CTL_REQ_BR = 8'b0000_1101;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
        rd_m = 0; rd_w = 0; result_src_e = 0; result_src_m = 0;
        pc_src_e = 0; reg_write_m = 0; mem_write_m = 0; reg_write_w = 0;
        dmem_if.dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        mem_write_m = 1; pc_src_e = 1; reg_write_m = 1; rd_m = 3; rs1_e = 3;
        result_src_e = 2'b01; rd_e = 2; rs1_d = 2;
        #1;
        tests_run++;
        if (ctl !== CTL_IDLE) begin
            tests_failed++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_IDLE);
        end
        tests_run++;
        if (forward_a_e !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_fwd: got %b expected 00", forward_a_e);
        end
        tests_run++;
        if ({stall_count, dmem_timeout, mem_state_dbg} !== {{CNT_W{1'b0}}, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset_state: got cnt=%0d to=%b st=%b expected 0/0/0",
                     stall_count, dmem_timeout, mem_state_dbg);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        idle_inputs();
        reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 0;
        #1;
        tests_run++;
        if ({forward_a_e, forward_b_e} !== 4'b10_00) begin
            tests_failed++;
            $display("FAIL fwd_m_priority: got a=%b b=%b expected a=10 b=00", forward_a_e, forward_b_e);
        end
        rd_m = 0;
        #1;
        tests_run++;
        if (forward_a_e !== 2'b01) begin
            tests_failed++;
            $display("FAIL fwd_w_when_rdm0: got %b expected 01", forward_a_e);
        end
        reg_write_m = 0; rd_m = 5; rs2_e = 5;
        #1;
        tests_run++;
        if ({forward_a_e, forward_b_e} !== 4'b01_01) begin
            tests_failed++;
            $display("FAIL fwd_w_both: got a=%b b=%b expected a=01 b=01", forward_a_e, forward_b_e);
        end
        reg_write_m = 1; rd_m = 9; rs2_e = 9; reg_write_w = 0;
        #1;
        tests_run++;
        if ({forward_a_e, forward_b_e} !== 4'b00_10) begin
            tests_failed++;
            $display("FAIL fwd_b_m: got a=%b b=%b expected a=00 b=10", forward_a_e, forward_b_e);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        #1;
        tests_run++;
        if (ctl !== CTL_LWS) begin
            tests_failed++;
            $display("FAIL load_use_ctl: got %b expected %b", ctl, CTL_LWS);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (stall_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL load_use_count: got %0d expected 1", stall_count);
        end
        result_src_e = 2'b01; rd_e = 0; rs1_d = 0; rs2_d = 0;
        #1;
        tests_run++;
        if (ctl !== CTL_IDLE) begin
            tests_failed++;
            $display("FAIL load_use_x0: got %b expected %b", ctl, CTL_IDLE);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (stall_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL load_use_x0_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        pc_src_e = 1;
        #1;
        tests_run++;
        if (ctl !== CTL_BR) begin
            tests_failed++;
            $display("FAIL branch_flush: got %b expected %b", ctl, CTL_BR);
        end
        result_src_e = 2'b01; rd_e = 3; rs1_d = 3;
        #1;
        tests_run++;
        if (ctl !== 8'b1100_1100) begin
            tests_failed++;
            $display("FAIL branch_with_lw: got %b expected 11001100", ctl);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (stall_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL branch_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_mem_wait(input bit with_branch);
        int req_cycles;
        logic [7:0] exp_ready;
        req_cycles = 0;
        exp_ready = with_branch ? CTL_REQ_BR : CTL_REQ;
        do_reset();
        @(negedge clk);
        mem_write_m = 1; dmem_if.dmem_ready = 1'b0; pc_src_e = with_branch;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (ctl !== CTL_MSTALL) begin
                tests_failed++;
                $display("FAIL mem_wait_stall[%0d] br=%0d: got %b expected %b", i, with_branch, ctl, CTL_MSTALL);
            end
            if (dmem_if.dmem_req) req_cycles++;
            if (i == 1) begin
                tests_run++;
                if (mem_state_dbg !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL mem_wait_state: got %b expected 1", mem_state_dbg);
                end
            end
            @(negedge clk);
        end
        dmem_if.dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== exp_ready) begin
            tests_failed++;
            $display("FAIL mem_wait_ready br=%0d: got %b expected %b", with_branch, ctl, exp_ready);
        end
        if (dmem_if.dmem_req) req_cycles++;
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (req_cycles !== 4) begin
            tests_failed++;
            $display("FAIL mem_wait_req_cycles: got %0d expected 4", req_cycles);
        end
        tests_run++;
        if ({stall_count, mem_state_dbg} !== {4'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL mem_wait_count: got cnt=%0d st=%b expected cnt=3 st=0", stall_count, mem_state_dbg);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk);
        result_src_m = 2'b01; dmem_if.dmem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            tests_run++;
            if (ctl !== CTL_MSTALL) begin
                tests_failed++;
                $display("FAIL timeout_stall[%0d]: got %b expected %b", i, ctl, CTL_MSTALL);
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if ({ctl, dmem_timeout} !== {CTL_REQ, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_release: got ctl=%b to=%b expected ctl=%b to=0", ctl, dmem_timeout, CTL_REQ);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if ({dmem_timeout, stall_count, mem_state_dbg} !== {1'b1, 4'd4, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_flag: got to=%b cnt=%0d st=%b expected to=1 cnt=4 st=0",
                     dmem_timeout, stall_count, mem_state_dbg);
        end
        @(negedge clk);
        mem_write_m = 1; dmem_if.dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_REQ) begin
            tests_failed++;
            $display("FAIL timeout_next_access: got %b expected %b", ctl, CTL_REQ);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if ({dmem_timeout, stall_count} !== {1'b1, 4'd4}) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got to=%b cnt=%0d expected to=1 cnt=4", dmem_timeout, stall_count);
        end
    endtask

    // Runs straight after test_timeout so dmem_timeout starts at 1.
    task automatic test_reset_mid_wait();
        @(negedge clk);
        mem_write_m = 1; dmem_if.dmem_ready = 1'b0;
        reg_write_m = 1; rd_m = 4; rs1_e = 4;
        @(negedge clk);
        #1;
        tests_run++;
        if ({ctl, mem_state_dbg} !== {CTL_MSTALL, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got ctl=%b st=%b expected ctl=%b st=1", ctl, mem_state_dbg, CTL_MSTALL);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({ctl, forward_a_e} !== {CTL_IDLE, 2'b00}) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got ctl=%b fwd=%b expected all 0", ctl, forward_a_e);
        end
        tests_run++;
        if ({stall_count, dmem_timeout, mem_state_dbg} !== {{CNT_W{1'b0}}, 2'b00}) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got cnt=%0d to=%b st=%b expected 0/0/0",
                     stall_count, dmem_timeout, mem_state_dbg);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        mem_write_m = 1; dmem_if.dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_REQ) begin
            tests_failed++;
            $display("FAIL rst_mid_zero_wait: got %b expected %b", ctl, CTL_REQ);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if ({stall_count, mem_state_dbg} !== {4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_mid_after: got cnt=%0d st=%b expected 0/0", stall_count, mem_state_dbg);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        mem_write_m = 1; dmem_if.dmem_ready = 1'b0;
        #1;
        tests_run++;
        if (ctl !== CTL_MSTALL) begin
            tests_failed++;
            $display("FAIL b2b_first_stall: got %b expected %b", ctl, CTL_MSTALL);
        end
        @(negedge clk);
        dmem_if.dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_REQ) begin
            tests_failed++;
            $display("FAIL b2b_first_ready: got %b expected %b", ctl, CTL_REQ);
        end
        @(negedge clk);
        mem_write_m = 0; result_src_m = 2'b01;
        #1;
        tests_run++;
        if (ctl !== CTL_REQ) begin
            tests_failed++;
            $display("FAIL b2b_zero_wait: got %b expected %b", ctl, CTL_REQ);
        end
        @(negedge clk);
        dmem_if.dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (ctl !== CTL_MSTALL) begin
                tests_failed++;
                $display("FAIL b2b_third_stall[%0d]: got %b expected %b", i, ctl, CTL_MSTALL);
            end
            @(negedge clk);
        end
        dmem_if.dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_REQ) begin
            tests_failed++;
            $display("FAIL b2b_third_ready: got %b expected %b", ctl, CTL_REQ);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if ({stall_count, mem_state_dbg} !== {4'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_count: got cnt=%0d st=%b expected cnt=3 st=0", stall_count, mem_state_dbg);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge clk);
        result_src_e = 2'b01; rd_e = 9; rs1_d = 9;
        repeat (20) @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (stall_count !== 4'hF) begin
            tests_failed++;
            $display("FAIL count_saturate: got %0d expected 15", stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait(1'b0);
        test_mem_wait(1'b1);
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
